// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt arbiter: FSM state encoding,
// cause-code width and the default cause base.
package irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam int CAUSE_W            = 5;
    localparam int DEFAULT_CAUSE_BASE = 16;

endpackage

// File: rtl/irq_sync.sv
// Per-line two-flop synchronizer plus one history flop; exposes the
// synchronized level and a single-cycle rising-edge indication.
module irq_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise
);

    logic s1_reg;
    logic s2_reg;
    logic s3_reg;

    // s3 resets low so a line already high at reset release yields one edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
            s3_reg <= 1'b0;
        end else begin
            s1_reg <= din;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
        end
    end

    assign level = s2_reg;
    assign rise  = s2_reg & ~s3_reg;

endmodule

// File: rtl/irq_arbiter.sv
// Fixed-priority interrupt arbiter: synchronizes external lines, keeps a
// pending vector and presents one non-nested request at a time.
module irq_arbiter
    import irq_pkg::*;
#(
    parameter int                 N_IRQ      = 8,
    parameter logic [N_IRQ-1:0]   EDGE_MASK  = '0,
    parameter int                 CAUSE_BASE = DEFAULT_CAUSE_BASE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_IRQ-1:0]   ext_irq,
    input  logic [N_IRQ-1:0]   irq_en,
    input  logic               mie,
    input  logic               int_ack,
    input  logic               int_done,
    output logic               int_req,
    output logic [CAUSE_W-1:0] int_cause,
    output logic [N_IRQ-1:0]   int_pending
);

    localparam int SEL_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    generate
        if (N_IRQ < 1 || N_IRQ > 16 || (CAUSE_BASE + N_IRQ - 1) > 31) begin : g_bad_cfg
            $error("irq_arbiter: N_IRQ must be 1..16 and CAUSE_BASE+N_IRQ-1 must fit in 5 bits");
        end
    endgenerate

    logic [N_IRQ-1:0]   sync_level;
    logic [N_IRQ-1:0]   sync_rise;
    logic [N_IRQ-1:0]   pending_reg;
    logic [N_IRQ-1:0]   pending_next;
    logic [N_IRQ-1:0]   eligible;
    logic [SEL_W-1:0]   win_idx;
    state_t             state_reg;
    state_t             state_next;
    logic [SEL_W-1:0]   sel_reg;
    logic [SEL_W-1:0]   sel_next;
    logic               int_req_reg;
    logic               int_req_next;
    logic [CAUSE_W-1:0] int_cause_reg;
    logic [CAUSE_W-1:0] int_cause_next;
    logic               ack_take;

    assign ack_take = (state_reg == ST_REQ) && int_ack;

    // Edge lines: set beats the ack-clear of the presented line
    generate
        for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_line
            irq_sync u_sync (
                .clk   (clk),
                .reset (reset),
                .din   (ext_irq[gi]),
                .level (sync_level[gi]),
                .rise  (sync_rise[gi])
            );

            assign pending_next[gi] = EDGE_MASK[gi]
                ? (sync_rise[gi] | (pending_reg[gi] & ~(ack_take && (sel_reg == SEL_W'(gi)))))
                : sync_level[gi];
        end
    endgenerate

    assign eligible = pending_reg & irq_en;

    always_comb begin
        win_idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        sel_next       = sel_reg;
        int_cause_next = int_cause_reg;
        case (state_reg)
            ST_IDLE: begin
                if (mie && (eligible != '0)) begin
                    state_next     = ST_REQ;
                    sel_next       = win_idx;
                    int_cause_next = CAUSE_W'(CAUSE_BASE) + CAUSE_W'(win_idx);
                end
            end
            ST_REQ: begin
                // Ack takes precedence over a simultaneous mie withdrawal
                if (int_ack) begin
                    state_next = ST_SERVICE;
                end else if (!mie) begin
                    state_next = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (int_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        int_req_next = (state_next == ST_REQ);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            sel_reg       <= '0;
            int_req_reg   <= 1'b0;
            int_cause_reg <= '0;
            pending_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            sel_reg       <= sel_next;
            int_req_reg   <= int_req_next;
            int_cause_reg <= int_cause_next;
            pending_reg   <= pending_next;
        end
    end

    assign int_req     = int_req_reg;
    assign int_cause   = int_cause_reg;
    assign int_pending = pending_reg;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter: lines 1,4,5 edge-triggered, others level.
module tb_irq_arbiter;

    logic       clk;
    logic       reset;
    logic [7:0] ext_irq;
    logic [7:0] irq_en;
    logic       mie;
    logic       int_ack;
    logic       int_done;
    logic       int_req;
    logic [4:0] int_cause;
    logic [7:0] int_pending;

    int total;
    int bad;

    irq_arbiter #(
        .N_IRQ      (8),
        .EDGE_MASK  (8'h32),
        .CAUSE_BASE (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ext_irq     (ext_irq),
        .irq_en      (irq_en),
        .mie         (mie),
        .int_ack     (int_ack),
        .int_done    (int_done),
        .int_req     (int_req),
        .int_cause   (int_cause),
        .int_pending (int_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        ext_irq  = 8'h00;
        irq_en   = 8'hFF;
        mie      = 1'b1;
        int_ack  = 1'b0;
        int_done = 1'b0;
        #1;
        check("rst_req", 32'(int_req), 32'd0);
        check("rst_cause", 32'(int_cause), 32'd0);
        check("rst_pend", 32'(int_pending), 32'd0);
        tick(2);
        reset = 1'b0;
        tick(1);

        // Level line 3: int_req three edges after first sample
        ext_irq[3] = 1'b1;
        tick(2);
        check("lvl3_k1_pend", 32'(int_pending), 32'h00);
        tick(1);
        check("lvl3_k2_pend", 32'(int_pending), 32'h08);
        check("lvl3_k2_req", 32'(int_req), 32'd0);
        tick(1);
        check("lvl3_k3_req", 32'(int_req), 32'd1);
        check("lvl3_cause", 32'(int_cause), 32'd19);
        ext_irq[3] = 1'b0;
        int_ack    = 1'b1;
        tick(1);
        int_ack = 1'b0;
        check("lvl3_ack_req", 32'(int_req), 32'd0);
        tick(3);
        check("lvl3_svc_pend", 32'(int_pending), 32'h00);
        int_done = 1'b1;
        tick(1);
        int_done = 1'b0;
        tick(1);
        check("lvl3_idle_req", 32'(int_req), 32'd0);

        // Edge lines 1 and 5 pulse together: 17 first, then 21 after done
        ext_irq = 8'h22;
        tick(1);
        ext_irq = 8'h00;
        tick(2);
        check("e15_pend", 32'(int_pending), 32'h22);
        tick(1);
        check("e15_req", 32'(int_req), 32'd1);
        check("e15_cause1", 32'(int_cause), 32'd17);
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
        check("e15_ack_req", 32'(int_req), 32'd0);
        check("e15_ack_pend", 32'(int_pending), 32'h20);
        int_done = 1'b1;
        tick(1);
        int_done = 1'b0;
        check("e15_done_req", 32'(int_req), 32'd0);
        tick(1);
        check("e15_b2b_req", 32'(int_req), 32'd1);
        check("e15_cause2", 32'(int_cause), 32'd21);
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
        check("e15_ack2_pend", 32'(int_pending), 32'h00);
        int_done = 1'b1;
        tick(1);
        int_done = 1'b0;
        tick(1);

        // Level line 2 gated by mie, then withdrawn by mie
        mie        = 1'b0;
        ext_irq[2] = 1'b1;
        tick(4);
        check("mie0_req", 32'(int_req), 32'd0);
        check("mie0_pend", 32'(int_pending), 32'h04);
        mie = 1'b1;
        tick(1);
        check("mie1_req", 32'(int_req), 32'd1);
        check("mie1_cause", 32'(int_cause), 32'd18);
        mie = 1'b0;
        tick(1);
        check("wdraw_req", 32'(int_req), 32'd0);
        check("wdraw_pend", 32'(int_pending), 32'h04);
        ext_irq[2] = 1'b0;
        tick(3);
        mie = 1'b1;
        tick(1);
        check("l2_gone_req", 32'(int_req), 32'd0);

        // Edge line 4 re-pulses during service: no nesting, presented after done
        ext_irq[4] = 1'b1;
        tick(1);
        ext_irq[4] = 1'b0;
        tick(3);
        check("e4_req", 32'(int_req), 32'd1);
        check("e4_cause", 32'(int_cause), 32'd20);
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
        ext_irq[4] = 1'b1;
        tick(1);
        ext_irq[4] = 1'b0;
        tick(3);
        check("e4_svc_req", 32'(int_req), 32'd0);
        check("e4_svc_pend", 32'(int_pending), 32'h10);
        int_done = 1'b1;
        tick(1);
        int_done = 1'b0;
        tick(1);
        check("e4_again_req", 32'(int_req), 32'd1);
        check("e4_again_cause", 32'(int_cause), 32'd20);
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
        int_done = 1'b1;
        tick(1);
        int_done = 1'b0;
        tick(1);

        // Ack and mie drop in the same cycle: ack wins
        ext_irq[3] = 1'b1;
        tick(4);
        check("ackmie_req", 32'(int_req), 32'd1);
        int_ack = 1'b1;
        mie     = 1'b0;
        tick(1);
        int_ack = 1'b0;
        mie     = 1'b1;
        tick(2);
        check("ackmie_svc_req", 32'(int_req), 32'd0);

        // Reset during service with edge line 5 held high across release
        ext_irq[5] = 1'b1;
        tick(1);
        reset      = 1'b1;
        ext_irq[3] = 1'b0;
        #1;
        check("rst_svc_req", 32'(int_req), 32'd0);
        check("rst_svc_cause", 32'(int_cause), 32'd0);
        check("rst_svc_pend", 32'(int_pending), 32'd0);
        tick(2);
        reset = 1'b0;
        tick(3);
        check("rel_pre_req", 32'(int_req), 32'd0);
        tick(1);
        check("rel_req", 32'(int_req), 32'd1);
        check("rel_cause", 32'(int_cause), 32'd21);
        int_ack = 1'b1;
        tick(1);
        int_ack = 1'b0;
        int_done = 1'b1;
        tick(1);
        int_done = 1'b0;
        tick(5);
        check("rel_once_req", 32'(int_req), 32'd0);
        check("rel_once_pend", 32'(int_pending), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
